// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one multi-byte UART TX push port between NREQ frame sources.
// Optional frame header byte {4'hA, grant id} is enabled by defining UART_TX_ARB_HDR_EN.
module uart_tx_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned N    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_valid_i,
  input  logic [NREQ*$clog2(N+1)-1:0]    req_len_i,
  input  logic [NREQ*N*8-1:0]            req_data_i,
  output logic [NREQ-1:0]                req_ack_o,
  output logic [N*8-1:0]                 data_o,
  output logic [$clog2(N+1)-1:0]         push_o,
  input  logic [$clog2(N+1)-1:0]         can_push_i,
  output logic                           busy_o,
  output logic [$clog2(NREQ)-1:0]        grant_id_o
);

  localparam int unsigned LW = $clog2(N+1);
  localparam int unsigned GW = $clog2(NREQ);
`ifdef UART_TX_ARB_HDR_EN
  localparam int unsigned NB = N + 1;
`else
  localparam int unsigned NB = N;
`endif
  localparam int unsigned RW = $clog2(NB+1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [NB*8-1:0] buf_q, buf_d;
  logic [NREQ-1:0] ack_d;
  logic [GW-1:0]   gid_d;

  logic [LW-1:0]   len_a  [NREQ];
  logic [N*8-1:0]  data_a [NREQ];
  logic            found;
  logic [GW-1:0]   g;
  logic [GW:0]     sum;
  logic [RW-1:0]   len_cl;
  logic [RW-1:0]   k;

  // Split the flat request buses into per-requester lanes
  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      len_a[r]  = req_len_i[r*LW +: LW];
      data_a[r] = req_data_i[r*N*8 +: N*8];
    end
  end

  // First valid requester at or after rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    g     = rr_ptr_q;
    sum   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr_q} + (GW+1)'(i);
      if (sum >= (GW+1)'(NREQ)) sum = sum - (GW+1)'(NREQ);
      if (!found && req_valid_i[GW'(sum)]) begin
        found = 1'b1;
        g     = GW'(sum);
      end
    end
  end

  // Clamped frame length of the winner, plus the header byte when enabled
  always_comb begin
    len_cl = (len_a[g] > LW'(N)) ? RW'(N) : RW'(len_a[g]);
`ifdef UART_TX_ARB_HDR_EN
    len_cl = len_cl + RW'(1);
`endif
  end

  // Bytes pushed this cycle: limited by remaining bytes, free slots and port width
  always_comb begin
    k = (RW'(can_push_i) < rem_q) ? RW'(can_push_i) : rem_q;
    if (k > RW'(N)) k = RW'(N);
  end

  assign push_o = (state_q == S_SEND) ? LW'(k) : '0;
  assign data_o = (state_q == S_SEND) ? buf_q[N*8-1:0] : '0;
  assign busy_o = (state_q == S_SEND);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    rem_d    = rem_q;
    buf_d    = buf_q;
    ack_d    = '0;
    gid_d    = grant_id_o;
    case (state_q)
      S_IDLE: begin
        // Hold off one cycle after a zero-length ack so the same frame is not granted twice
        if (found && !(|req_ack_o)) begin
`ifdef UART_TX_ARB_HDR_EN
          buf_d = {data_a[g], 4'hA, 4'(g)};
`else
          buf_d = data_a[g];
`endif
          rem_d    = len_cl;
          gid_d    = g;
          ack_d[g] = 1'b1;
          rr_ptr_d = ({1'b0, g} == (GW+1)'(NREQ-1)) ? '0 : g + GW'(1);
          if (len_cl != '0) state_d = S_SEND;
        end
      end
      S_SEND: begin
        buf_d = buf_q >> {k, 3'b000};
        rem_d = rem_q - k;
        if (rem_q == k) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      rem_q      <= '0;
      buf_q      <= '0;
      req_ack_o  <= '0;
      grant_id_o <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rem_q      <= rem_d;
      buf_q      <= buf_d;
      req_ack_o  <= ack_d;
      grant_id_o <= gid_d;
    end
  end

endmodule
